mac_arbiter: RTL

- Shares the single combinational mac_wrapper datapath between NUM_REQ independent requesters.
- Each request carries one operand set: input_1..input_4, 16 bits each.
- Grants round-robin, registers operands into the MAC, waits MAC_LATENCY cycles, then returns {output_1, output_2} tagged with the requester index over a valid/ready response channel.
- Sits between the per-requester front ends (AXI-lite register banks, DMA feeders) and mac_wrapper.

---
 rtl/mac_arb_pkg.sv | 18 +
 rtl/mac_arbiter_rr_arbiter.sv | 35 +++
 rtl/mac_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_arb_pkg.sv
// Shared types, constants and the operand-slice helper for the MAC arbiter.
package mac_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned OPS_CNT_WIDTH      = 16;
  localparam int unsigned LAT_CNT_WIDTH      = 4;
  localparam int unsigned OPERANDS           = 4;

  // Bit offset of operand opnd (0 = input_1, the MSB word) of requester req.
  function automatic int unsigned operand_offset(input int unsigned req,
                                                 input int unsigned opnd,
                                                 input int unsigned width);
    return (req * OPERANDS + (OPERANDS - 1 - opnd)) * width;
  endfunction

endpackage

// File: rtl/mac_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  localparam int unsigned NR = NUM_REQ;

  logic                found;
  int unsigned         cand;
  logic [ID_WIDTH-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NR; off++) begin
      cand     = (32'(rr_ptr) + off) % NR;
      cand_idx = ID_WIDTH'(cand);
      if (!found && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin front end sharing one combinational MAC datapath between NUM_REQ requesters.
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MAC_LATENCY = 1,
  parameter int ID_WIDTH    = 2
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*4*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           mac_input_1,
  output logic [DATA_WIDTH-1:0]           mac_input_2,
  output logic [DATA_WIDTH-1:0]           mac_input_3,
  output logic [DATA_WIDTH-1:0]           mac_input_4,
  input  logic [DATA_WIDTH-1:0]           mac_output_1,
  input  logic [DATA_WIDTH-1:0]           mac_output_2,
  output logic                            rsp_valid,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic [2*DATA_WIDTH-1:0]         rsp_data,
  input  logic                            rsp_ready,
  output logic                            busy,
  output logic [OPS_CNT_WIDTH-1:0]        ops_done
);

  if (ID_WIDTH != $clog2(NUM_REQ)) begin : g_bad_id_width
    $error("mac_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mac_arbiter: NUM_REQ must be within 2..8");
  end
  if (MAC_LATENCY < 1 || MAC_LATENCY > 15) begin : g_bad_latency
    $error("mac_arbiter: MAC_LATENCY must be within 1..15");
  end

  state_t                   state, state_next;
  logic [ID_WIDTH-1:0]      rr_ptr, granted, next_ptr;
  logic [LAT_CNT_WIDTH-1:0] counter;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_WIDTH-1:0]      grant_idx;
  logic                     hs, done;
  logic [DATA_WIDTH-1:0]    sel_op [OPERANDS];

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = WAIT;
      WAIT:    if (counter == LAT_CNT_WIDTH'(1)) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // req_ready is also gated by reset so it reads 0 while reset is held.
  always_comb begin
    req_ready = (state == IDLE && s_axi_aresetn) ? grant : '0;
    hs        = |(req_valid & req_ready);
    done      = (state == RESP) && rsp_ready;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_comb begin
    for (int unsigned k = 0; k < OPERANDS; k++) sel_op[k] = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        for (int unsigned k = 0; k < OPERANDS; k++)
          sel_op[k] = req_data[operand_offset(i, k, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign next_ptr = (granted == ID_WIDTH'(NUM_REQ - 1)) ? '0 : granted + ID_WIDTH'(1);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      mac_input_1 <= '0;
      mac_input_2 <= '0;
      mac_input_3 <= '0;
      mac_input_4 <= '0;
      granted     <= '0;
      counter     <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rr_ptr      <= '0;
      ops_done    <= '0;
    end else begin
      if (hs) begin
        mac_input_1 <= sel_op[0];
        mac_input_2 <= sel_op[1];
        mac_input_3 <= sel_op[2];
        mac_input_4 <= sel_op[3];
        granted     <= grant_idx;
        counter     <= LAT_CNT_WIDTH'(MAC_LATENCY);
      end else if (state == WAIT) begin
        counter <= counter - LAT_CNT_WIDTH'(1);
        if (counter == LAT_CNT_WIDTH'(1)) begin
          rsp_data <= {mac_output_1, mac_output_2};
          rsp_id   <= granted;
        end
      end
      if (done) begin
        ops_done <= ops_done + OPS_CNT_WIDTH'(1);
        rr_ptr   <= next_ptr;
      end
    end
  end

endmodule
